// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel millisecond timer.
package timer_pkg;

  typedef enum logic {T_IDLE, T_RUN} tstate_t;

  // Prescaler limit in clk cycles per ms; turbo divides it, never below 1.
  function automatic int ms_limit(input int clk_hz, input int turbo_shift, input logic turbo);
    int pre;
    int lim;
    pre = clk_hz / 1000;
    if (pre < 1) pre = 1;
    lim = turbo ? (pre >> turbo_shift) : pre;
    if (lim < 1) lim = 1;
    return lim;
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond prescaler: one-cycle ms_tick per (turbo-scaled) millisecond, frozen by pause.
module ms_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TURBO_SHIFT = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic turbo,
  input  logic pause,
  output logic ms_tick
);

  localparam int PRE   = ms_limit(CLK_HZ, TURBO_SHIFT, 1'b0);
  localparam int LIM_T = ms_limit(CLK_HZ, TURBO_SHIFT, 1'b1);
  localparam int CNT_W = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(PRE - 1);
  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(LIM_T - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;

  assign last = turbo ? LAST_T : LAST_N;

  // >= rather than == so a turbo switch with count past the short limit wraps at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count   <= '0;
      ms_tick <= 1'b0;
    end else if (pause) begin
      ms_tick <= 1'b0;
    end else if (count >= last) begin
      count   <= '0;
      ms_tick <= 1'b1;
    end else begin
      count   <= count + 1'b1;
      ms_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_channel_timer.sv
// N_CH programmable millisecond timers sharing one prescaler; each gives a tick pulse,
// a 50% toggle output and a busy flag.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter  int CLK_HZ      = 50_000_000,
  parameter  int N_CH        = 4,
  parameter  int PERIOD_W    = 16,
  parameter  int TURBO_SHIFT = 4,
  parameter  int DEF_PERIOD  = 1000,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                turbo,
  input  logic                pause,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_oneshot,
  input  logic [N_CH-1:0]     start,
  input  logic [N_CH-1:0]     stop,
  output logic                ms_tick,
  output logic [N_CH-1:0]     tick,
  output logic [N_CH-1:0]     duty50,
  output logic [N_CH-1:0]     busy
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  ms_prescaler #(
    .CLK_HZ      (CLK_HZ),
    .TURBO_SHIFT (TURBO_SHIFT)
  ) u_prescaler (
    .clk     (clk),
    .resetN  (resetN),
    .turbo   (turbo),
    .pause   (pause),
    .ms_tick (ms_tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tstate_t             state, state_nxt;
    logic [PERIOD_W-1:0] period_q, period_eff;
    logic [PERIOD_W-1:0] remaining, remaining_nxt;
    logic                oneshot_q, oneshot_eff;
    logic                tick_q, tick_nxt;
    logic                duty_q, duty_nxt;
    logic                cfg_hit;

    // A same-cycle config write is visible to a start or reload in that cycle.
    assign cfg_hit     = cfg_we && (cfg_ch == CH_W'(i));
    assign period_eff  = cfg_hit ? ((cfg_period == '0) ? ONE : cfg_period) : period_q;
    assign oneshot_eff = cfg_hit ? cfg_oneshot : oneshot_q;

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        period_q  <= PERIOD_W'(DEF_PERIOD);
        oneshot_q <= 1'b0;
      end else if (cfg_hit) begin
        period_q  <= period_eff;
        oneshot_q <= oneshot_eff;
      end
    end

    always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      duty_nxt      = duty_q;
      tick_nxt      = 1'b0;
      if (stop[i]) begin
        state_nxt = T_IDLE;
      end else if (start[i]) begin
        state_nxt     = T_RUN;
        remaining_nxt = period_eff;
        duty_nxt      = 1'b0;
      end else if (state == T_RUN && ms_tick && !pause) begin
        if (remaining > ONE) begin
          remaining_nxt = remaining - ONE;
        end else begin
          tick_nxt = 1'b1;
          duty_nxt = ~duty_q;
          if (oneshot_eff) state_nxt = T_IDLE;
          else             remaining_nxt = period_eff;
        end
      end
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        state     <= T_IDLE;
        remaining <= '0;
        tick_q    <= 1'b0;
        duty_q    <= 1'b0;
      end else begin
        state     <= state_nxt;
        remaining <= remaining_nxt;
        tick_q    <= tick_nxt;
        duty_q    <= duty_nxt;
      end
    end

    assign tick[i]   = tick_q;
    assign duty50[i] = duty_q;
    assign busy[i]   = (state == T_RUN);
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Scoreboard bench for multi_channel_timer at CLK_HZ=32_000 (PRE=32, turbo limit 2), N_CH=3
// so that cfg_ch=3 is an out-of-range channel.
module tb_multi_channel_timer;

  localparam int N_CH = 3;
  localparam int PW   = 16;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic            turbo = 1'b0;
  logic            pause = 1'b0;
  logic            cfg_we = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [PW-1:0]   cfg_period = '0;
  logic            cfg_oneshot = 1'b0;
  logic [N_CH-1:0] start = '0;
  logic [N_CH-1:0] stop = '0;
  logic            ms_tick;
  logic [N_CH-1:0] tick, duty50, busy;

  int cyc;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int at;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  multi_channel_timer #(
    .CLK_HZ      (32_000),
    .N_CH        (N_CH),
    .PERIOD_W    (PW),
    .TURBO_SHIFT (4),
    .DEF_PERIOD  (1000)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .turbo       (turbo),
    .pause       (pause),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .ms_tick     (ms_tick),
    .tick        (tick),
    .duty50      (duty50),
    .busy        (busy)
  );

  // Edges since resetN was released; outputs are sampled on the falling edge.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic pushExp(input int ch, input int at);
    exp_t e;
    e.ch = ch;
    e.at = at;
    sb.push_back(e);
  endtask

  // Every tick pulse must match the oldest pending expectation for its channel.
  always @(negedge clk) begin
    if (resetN) begin
      for (int i = 0; i < N_CH; i++) begin
        if (tick[i]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].ch == i) idx = k;
          if (idx < 0) begin
            checkOutput($sformatf("tick_unexpected_ch%0d", i), cyc, -1);
          end else begin
            checkOutput($sformatf("tick_time_ch%0d", i), cyc, sb[idx].at);
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic waitCyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drive one cycle of config/strobe inputs; call on a falling edge.
  task automatic applyStimulus(input logic we, input logic [CH_W-1:0] ch, input logic [PW-1:0] per,
                               input logic os, input logic [N_CH-1:0] st, input logic [N_CH-1:0] sp);
    cfg_we      = we;
    cfg_ch      = ch;
    cfg_period  = per;
    cfg_oneshot = os;
    start       = st;
    stop        = sp;
    @(negedge clk);
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_period  = '0;
    cfg_oneshot = 1'b0;
    start       = '0;
    stop        = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    resetN = 1'b0;
    turbo  = 1'b0;
    pause  = 1'b0;
    start  = '0;
    stop   = '0;
    cfg_we = 1'b0;
    @(negedge clk);
    checkOutput("rst_ms_tick", 32'(ms_tick), 0);
    checkOutput("rst_tick",    32'(tick),    0);
    checkOutput("rst_duty50",  32'(duty50),  0);
    checkOutput("rst_busy",    32'(busy),    0);
    resetN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Prescaler after reset: first ms_tick 32 cycles after release, then every 32.
    doReset();
    waitCyc(31); checkOutput("ms_tick_c31", 32'(ms_tick), 0);
    waitCyc(32); checkOutput("ms_tick_c32", 32'(ms_tick), 1);
    waitCyc(33); checkOutput("ms_tick_c33", 32'(ms_tick), 0);
    waitCyc(64); checkOutput("ms_tick_c64", 32'(ms_tick), 1);

    // ch0 periodic P=3 and ch1 one-shot P=2, each written in the same cycle as its start.
    doReset();
    pushExp(1, 65);
    pushExp(0, 97);
    pushExp(0, 193);
    pushExp(0, 289);
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b0, 3'b001, 3'b000);
    applyStimulus(1'b1, 2'd1, 16'd2, 1'b1, 3'b010, 3'b000);
    checkOutput("busy0_run", 32'(busy[0]), 1);
    checkOutput("busy1_run", 32'(busy[1]), 1);
    waitCyc(64);  checkOutput("busy1_pre_expiry", 32'(busy[1]), 1);
    waitCyc(65);  checkOutput("tick1_oneshot", 32'(tick[1]), 1);
    checkOutput("busy1_drops_with_tick", 32'(busy[1]), 0);
    checkOutput("duty1_toggled", 32'(duty50[1]), 1);
    waitCyc(97);  checkOutput("duty0_first", 32'(duty50[0]), 1);
    waitCyc(193); checkOutput("duty0_second", 32'(duty50[0]), 0);
    waitCyc(300);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b001);
    waitCyc(302);
    checkOutput("busy0_stopped", 32'(busy[0]), 0);
    checkOutput("duty0_held", 32'(duty50[0]), 1);
    waitCyc(400);
    checkOutput("sb_empty_basic", sb.size(), 0);

    // Turbo asserted at prescaler count 20.
    doReset();
    pushExp(0, 26);
    pushExp(0, 32);
    pushExp(0, 38);
    pushExp(0, 44);
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b0, 3'b001, 3'b000);
    waitCyc(20); checkOutput("turbo_c20", 32'(ms_tick), 0);
    turbo = 1'b1;
    waitCyc(21); checkOutput("turbo_c21", 32'(ms_tick), 1);
    waitCyc(22); checkOutput("turbo_c22", 32'(ms_tick), 0);
    waitCyc(23); checkOutput("turbo_c23", 32'(ms_tick), 1);
    waitCyc(45);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b001);
    turbo = 1'b0;
    waitCyc(60);
    checkOutput("turbo_busy0_stopped", 32'(busy[0]), 0);
    checkOutput("sb_empty_turbo", sb.size(), 0);

    // Pause for 100 cycles mid-period shifts the ch0 tick from 97 to 197.
    doReset();
    pushExp(0, 197);
    pushExp(0, 293);
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b0, 3'b001, 3'b000);
    waitCyc(40);
    pause = 1'b1;
    waitCyc(64);  checkOutput("pause_no_ms_tick", 32'(ms_tick), 0);
    waitCyc(97);  checkOutput("pause_no_tick", 32'(tick[0]), 0);
    checkOutput("pause_busy_held", 32'(busy[0]), 1);
    waitCyc(140);
    pause = 1'b0;
    waitCyc(164); checkOutput("pause_ms_shifted", 32'(ms_tick), 1);
    waitCyc(300);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b001);
    waitCyc(320);
    checkOutput("sb_empty_pause", sb.size(), 0);

    // ch2: start+stop together, period 0 stored as 1, out-of-range cfg_ch ignored.
    doReset();
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 3'b100, 3'b100);
    waitCyc(2); checkOutput("startstop_idle", 32'(busy[2]), 0);
    pushExp(2, 33);
    pushExp(2, 65);
    pushExp(2, 97);
    pushExp(2, 129);
    pushExp(2, 161);
    waitCyc(3);
    applyStimulus(1'b1, 2'd2, 16'd0, 1'b0, 3'b100, 3'b000);
    waitCyc(100);
    applyStimulus(1'b1, 2'd3, 16'd7, 1'b1, 3'b100, 3'b000);
    waitCyc(130); checkOutput("bad_ch_ignored_busy", 32'(busy[2]), 1);
    waitCyc(170);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b100);
    waitCyc(172); checkOutput("busy2_stopped", 32'(busy[2]), 0);
    waitCyc(200);
    checkOutput("sb_empty_ch2", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
